// File: rtl/ibex_rf_wbuf_pkg.sv
// Shared types and helpers for the register-file write-back buffer.
// Each entry holds a valid bit, the destination register and the write data.
// The stored data field is WBUF_DATA_W bits wide. The top-level DataWidth
// defaults to that width.
package ibex_rf_wbuf_pkg;

    localparam int unsigned WBUF_DATA_W = 32;

    // x0 is hard-wired to zero, so it is never buffered and never forwarded.
    localparam logic [4:0] RF_ADDR_X0 = 5'd0;

    typedef struct packed {
        logic                   valid;
        logic [4:0]             addr;
        logic [WBUF_DATA_W-1:0] data;
    } wbuf_entry_t;

    // Pointer width for a power-of-two buffer depth. It is at least one bit.
    function automatic int unsigned wbuf_ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ibex_rf_wbuf_match.sv
// Address lookup across all buffer entries.
// When several valid entries share the address, the youngest one wins. Age is
// measured backwards from the tail pointer, so the slot just behind the tail
// is the most recent allocation. Reads of x0 never match.
module ibex_rf_wbuf_match
    import ibex_rf_wbuf_pkg::*;
#(
    parameter int unsigned Depth = 4,
    localparam int unsigned PtrW = wbuf_ptr_w(Depth)
) (
    input  logic [Depth-1:0]      i_valid,
    input  logic [Depth-1:0][4:0] i_addr,
    input  logic [PtrW-1:0]       i_tail,
    input  logic [4:0]            i_raddr,
    output logic                  o_hit,
    output logic [PtrW-1:0]       o_idx
);

    logic [PtrW-1:0] w_idx;

    // Walk from the oldest slot to the youngest. Each later match overrides
    // an earlier one, so the youngest match is what remains at the end.
    always_comb begin
        o_hit = 1'b0;
        o_idx = '0;
        w_idx = '0;
        for (int k = Depth; k >= 1; k--) begin
            w_idx = i_tail - PtrW'(k);
            if (i_valid[w_idx] && (i_addr[w_idx] == i_raddr) &&
                (i_raddr != RF_ADDR_X0)) begin
                o_hit = 1'b1;
                o_idx = w_idx;
            end
        end
    end

endmodule

// File: rtl/ibex_rf_write_buffer.sv
// Write-back buffer between the Ibex writeback path and the two-level
// register file. Register writes are absorbed into a small circular FIFO and
// drained whenever the register file accepts the offered head entry. Pending
// data is forwarded to both operand read ports, so no read observes a stale
// value.
//
// Optional feature: define IBEX_RF_WBUF_COALESCE_EN to merge a write into an
// existing non-head entry for the same register instead of allocating a new
// entry.
module ibex_rf_write_buffer
    import ibex_rf_wbuf_pkg::*;
#(
    parameter int unsigned DataWidth = WBUF_DATA_W,
    parameter int unsigned Depth     = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 wb_we_i,
    input  logic [4:0]           wb_waddr_i,
    input  logic [DataWidth-1:0] wb_wdata_i,
    output logic                 wb_stall_o,
    output logic                 rf_we_o,
    output logic [4:0]           rf_waddr_o,
    output logic [DataWidth-1:0] rf_wdata_o,
    input  logic                 rf_wready_i,
    input  logic [4:0]           raddr_a_i,
    input  logic [4:0]           raddr_b_i,
    output logic                 fwd_hit_a_o,
    output logic                 fwd_hit_b_o,
    output logic [DataWidth-1:0] fwd_data_a_o,
    output logic [DataWidth-1:0] fwd_data_b_o,
    output logic                 empty_o
);

    localparam int unsigned PtrW = wbuf_ptr_w(Depth);
    localparam int unsigned CntW = PtrW + 1;

    typedef logic [DataWidth-1:0]   data_t;
    typedef logic [WBUF_DATA_W-1:0] store_t;

    wbuf_entry_t     r_entries [Depth];
    logic [PtrW-1:0] r_head;
    logic [PtrW-1:0] r_tail;
    logic [CntW-1:0] r_count;

    logic                  w_full;
    logic                  w_wr_acc;
    logic                  w_deq;
    logic                  w_alloc;
    logic                  w_coalesce;
    logic [PtrW-1:0]       w_co_idx;
    logic [Depth-1:0]      w_valid;
    logic [Depth-1:0][4:0] w_addr;
    logic [1:0][4:0]       w_raddr;
    logic [1:0]            w_fwd_hit;
    data_t                 w_fwd_data [2];

    genvar gi;

    // Flatten the entry valid bits and addresses for the lookup blocks.
    generate
        for (gi = 0; gi < Depth; gi++) begin : g_flat
            assign w_valid[gi] = r_entries[gi].valid;
            assign w_addr[gi]  = r_entries[gi].addr;
        end
    endgenerate

    // The stall depends only on registered occupancy. A drain in the same
    // cycle does not open a slot until the next cycle.
    assign w_full     = (r_count == CntW'(Depth));
    assign wb_stall_o = w_full;
    assign empty_o    = (r_count == '0);

    // The head entry is offered directly from storage. The head pointer only
    // moves on acceptance, so the offer stays stable while it waits.
    assign rf_we_o    = r_entries[r_head].valid;
    assign rf_waddr_o = r_entries[r_head].addr;
    assign rf_wdata_o = data_t'(r_entries[r_head].data);

    // A write to x0 is accepted without stalling and then dropped.
    assign w_wr_acc = wb_we_i && !w_full && (wb_waddr_i != RF_ADDR_X0);
    assign w_deq    = rf_we_o && rf_wready_i;

`ifdef IBEX_RF_WBUF_COALESCE_EN
    logic w_co_hit;

    ibex_rf_wbuf_match #(
        .Depth (Depth)
    ) u_match_co (
        .i_valid (w_valid),
        .i_addr  (w_addr),
        .i_tail  (r_tail),
        .i_raddr (wb_waddr_i),
        .o_hit   (w_co_hit),
        .o_idx   (w_co_idx)
    );

    // Merge only into a non-head entry. The head is always on offer, so a
    // matching write appends behind it rather than changing it.
    assign w_coalesce = w_wr_acc && w_co_hit && (w_co_idx != r_head);
`else
    assign w_coalesce = 1'b0;
    assign w_co_idx   = '0;
`endif

    assign w_alloc = w_wr_acc && !w_coalesce;

    // Per read port: a same-cycle accepted write wins. Otherwise the youngest
    // buffered match supplies the data. Otherwise there is no hit.
    assign w_raddr = {raddr_b_i, raddr_a_i};

    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic            w_hit;
            logic [PtrW-1:0] w_idx;

            ibex_rf_wbuf_match #(
                .Depth (Depth)
            ) u_match (
                .i_valid (w_valid),
                .i_addr  (w_addr),
                .i_tail  (r_tail),
                .i_raddr (w_raddr[gi]),
                .o_hit   (w_hit),
                .o_idx   (w_idx)
            );

            // Select the forwarded value for this read port.
            always_comb begin
                w_fwd_hit[gi]  = 1'b0;
                w_fwd_data[gi] = '0;
                if (w_wr_acc && (wb_waddr_i == w_raddr[gi])) begin
                    w_fwd_hit[gi]  = 1'b1;
                    w_fwd_data[gi] = wb_wdata_i;
                end else if (w_hit) begin
                    w_fwd_hit[gi]  = 1'b1;
                    w_fwd_data[gi] = data_t'(r_entries[w_idx].data);
                end
            end
        end
    endgenerate

    assign fwd_hit_a_o  = w_fwd_hit[0];
    assign fwd_hit_b_o  = w_fwd_hit[1];
    assign fwd_data_a_o = w_fwd_data[0];
    assign fwd_data_b_o = w_fwd_data[1];

    // FIFO state update: allocate at the tail, merge in place, retire at the
    // head. An entry keeps forwarding through its acceptance cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < Depth; i++) begin
                r_entries[i] <= '0;
            end
        end else begin
            if (w_alloc) begin
                r_entries[r_tail] <= '{valid: 1'b1, addr: wb_waddr_i,
                                       data: store_t'(wb_wdata_i)};
                r_tail <= r_tail + PtrW'(1);
            end
            if (w_coalesce) begin
                r_entries[w_co_idx].data <= store_t'(wb_wdata_i);
            end
            if (w_deq) begin
                r_entries[r_head].valid <= 1'b0;
                r_head <= r_head + PtrW'(1);
            end
            case ({w_alloc, w_deq})
                2'b10:   r_count <= r_count + CntW'(1);
                2'b01:   r_count <= r_count - CntW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_ibex_rf_write_buffer.sv
// Self-checking bench for ibex_rf_write_buffer.
// A queue-based model tracks the pending writes, oldest first. Every falling
// edge the outputs are compared against it. Directed steps add literal checks.
module tb_ibex_rf_write_buffer;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        wb_stall;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        rf_wready;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic        hit_a;
    logic        hit_b;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic        empty;

    int errors = 0;
    int checks = 0;

    ibex_rf_write_buffer #(
        .DataWidth (32),
        .Depth     (DEPTH)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .wb_we_i      (wb_we),
        .wb_waddr_i   (wb_waddr),
        .wb_wdata_i   (wb_wdata),
        .wb_stall_o   (wb_stall),
        .rf_we_o      (rf_we),
        .rf_waddr_o   (rf_waddr),
        .rf_wdata_o   (rf_wdata),
        .rf_wready_i  (rf_wready),
        .raddr_a_i    (ra),
        .raddr_b_i    (rb),
        .fwd_hit_a_o  (hit_a),
        .fwd_hit_b_o  (hit_b),
        .fwd_data_a_o (data_a),
        .fwd_data_b_o (data_b),
        .empty_o      (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a queue of pending writes, oldest first.
    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t mq[$];
    ent_t m_e;
    bit   m_acc;
    bit   m_deq;
    int   m_ci;

    always @(negedge rst_n) mq.delete();

    always @(posedge clk) begin
        if (!rst_n) begin
            mq.delete();
        end else begin
            m_acc = wb_we && (mq.size() != DEPTH) && (wb_waddr != 5'd0);
            m_deq = (mq.size() != 0) && rf_wready;
            m_ci  = -1;
`ifdef IBEX_RF_WBUF_COALESCE_EN
            if (m_acc)
                for (int i = 1; i < mq.size(); i++)
                    if (mq[i].a == wb_waddr) m_ci = i;
`endif
            if (m_acc) begin
                if (m_ci >= 0) begin
                    mq[m_ci].d = wb_wdata;
                end else begin
                    m_e.a = wb_waddr;
                    m_e.d = wb_wdata;
                    mq.push_back(m_e);
                end
            end
            if (m_deq) void'(mq.pop_front());
        end
    end

    function automatic void exp_fwd(input logic [4:0] r, output logic h, output logic [31:0] d);
        h = 1'b0;
        d = '0;
        if (r == 5'd0) return;
        if (wb_we && (mq.size() != DEPTH) && (wb_waddr != 5'd0) && (wb_waddr == r)) begin
            h = 1'b1;
            d = wb_wdata;
            return;
        end
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].a == r) begin
                h = 1'b1;
                d = mq[i].d;
                return;
            end
        end
    endfunction

    logic        e_h;
    logic [31:0] e_d;

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk1("rf_we", rf_we, mq.size() != 0);
        if (mq.size() != 0) begin
            chk32("rf_waddr", {27'b0, rf_waddr}, {27'b0, mq[0].a});
            chk32("rf_wdata", rf_wdata, mq[0].d);
        end
        chk1("stall", wb_stall, mq.size() == DEPTH);
        chk1("empty", empty, mq.size() == 0);
        exp_fwd(ra, e_h, e_d);
        chk1("hit_a", hit_a, e_h);
        chk32("data_a", data_a, e_d);
        exp_fwd(rb, e_h, e_d);
        chk1("hit_b", hit_b, e_h);
        chk32("data_b", data_b, e_d);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [4:0] a, input logic [31:0] d, input logic rdy);
        wb_we     = we;
        wb_waddr  = a;
        wb_wdata  = d;
        rf_wready = rdy;
        if (we) $display("txn: write x%0d = %h (rf_wready=%b)", a, d, rdy);
    endtask

    initial begin
        rst_n = 1'b0;
        ra = 5'd0;
        rb = 5'd0;
        drive(1'b0, 5'd0, 32'd0, 1'b0);
        cyc();
        cyc();
        @(negedge clk);
        chk1("rst_rf_we", rf_we, 1'b0);
        chk1("rst_stall", wb_stall, 1'b0);
        chk1("rst_empty", empty, 1'b1);
        chk1("rst_hit_a", hit_a, 1'b0);
        chk32("rst_data_a", data_a, 32'h0);
        cyc();
        rst_n = 1'b1;

        // Single write, drained immediately.
        drive(1'b1, 5'd5, 32'hA5A5A5A5, 1'b1);
        @(negedge clk);
        chk1("x5_not_yet_offered", rf_we, 1'b0);
        cyc();
        drive(1'b0, 5'd0, 32'd0, 1'b1);
        @(negedge clk);
        chk1("x5_rf_we", rf_we, 1'b1);
        chk32("x5_rf_waddr", {27'b0, rf_waddr}, 32'd5);
        chk32("x5_rf_wdata", rf_wdata, 32'hA5A5A5A5);
        cyc();
        @(negedge clk);
        chk1("x5_empty_after", empty, 1'b1);

        // Fill to full with the drain blocked, then hold a fifth write.
        for (int i = 1; i <= 4; i++) begin
            cyc();
            drive(1'b1, 5'(i), 32'(i * 17), 1'b0);
        end
        cyc();
        drive(1'b1, 5'd6, 32'h66, 1'b0);
        @(negedge clk);
        chk1("full_stall", wb_stall, 1'b1);
        cyc();
        @(negedge clk);
        chk1("full_stall_hold", wb_stall, 1'b1);
        cyc();
        drive(1'b1, 5'd6, 32'h66, 1'b1);
        @(negedge clk);
        chk1("full_stall_drain", wb_stall, 1'b1);
        chk32("drain_x1", {27'b0, rf_waddr}, 32'd1);
        cyc();
        @(negedge clk);
        chk1("stall_released", wb_stall, 1'b0);
        chk32("drain_x2", {27'b0, rf_waddr}, 32'd2);
        cyc();
        drive(1'b0, 5'd0, 32'd0, 1'b1);
        @(negedge clk);
        chk32("drain_x3", {27'b0, rf_waddr}, 32'd3);
        cyc();
        @(negedge clk);
        chk32("drain_x4", {27'b0, rf_waddr}, 32'd4);
        cyc();
        @(negedge clk);
        chk32("drain_x6", {27'b0, rf_waddr}, 32'd6);
        chk32("drain_x6_data", rf_wdata, 32'h66);
        cyc();
        @(negedge clk);
        chk1("drained_empty", empty, 1'b1);

        // Same register written twice behind a different head entry.
        cyc();
        drive(1'b1, 5'd8, 32'h80, 1'b0);
        cyc();
        drive(1'b1, 5'd7, 32'd1, 1'b0);
        cyc();
        drive(1'b1, 5'd7, 32'd2, 1'b0);
        cyc();
        drive(1'b0, 5'd0, 32'd0, 1'b0);
        ra = 5'd7;
        @(negedge clk);
        chk1("x7_hit", hit_a, 1'b1);
        chk32("x7_youngest", data_a, 32'd2);
        cyc();
        drive(1'b0, 5'd0, 32'd0, 1'b1);
        @(negedge clk);
        chk32("x8_head", {27'b0, rf_waddr}, 32'd8);
        cyc();
        @(negedge clk);
        chk32("x7_second_addr", {27'b0, rf_waddr}, 32'd7);
`ifdef IBEX_RF_WBUF_COALESCE_EN
        chk32("x7_merged_data", rf_wdata, 32'd2);
        cyc();
        @(negedge clk);
        chk1("x7_merged_empty", empty, 1'b1);
`else
        chk32("x7_first_data", rf_wdata, 32'd1);
        cyc();
        @(negedge clk);
        chk32("x7_third_data", rf_wdata, 32'd2);
`endif
        cyc();
        cyc();

        // Same-cycle bypass to both read ports.
        ra = 5'd9;
        rb = 5'd9;
        drive(1'b1, 5'd9, 32'h55, 1'b1);
        @(negedge clk);
        chk1("bypass_hit_a", hit_a, 1'b1);
        chk32("bypass_data_a", data_a, 32'h55);
        chk1("bypass_hit_b", hit_b, 1'b1);
        cyc();
        drive(1'b0, 5'd0, 32'd0, 1'b1);
        cyc();
        cyc();

        // A write to x0 is dropped, and a read of x0 never hits.
        rb = 5'd0;
        drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1);
        @(negedge clk);
        chk1("x0_hit_b", hit_b, 1'b0);
        chk1("x0_no_stall", wb_stall, 1'b0);
        cyc();
        drive(1'b0, 5'd0, 32'd0, 1'b1);
        @(negedge clk);
        chk1("x0_empty", empty, 1'b1);

        // Three entries, one drains, then reset is applied mid-drain.
        for (int i = 0; i < 3; i++) begin
            cyc();
            drive(1'b1, 5'(10 + i), 32'(32'hC0 + i), 1'b0);
        end
        cyc();
        drive(1'b0, 5'd0, 32'd0, 1'b1);
        ra = 5'd11;
        @(negedge clk);
        chk1("pre_rst_hit", hit_a, 1'b1);
        cyc();
        rst_n = 1'b0;
        @(negedge clk);
        chk1("mid_rst_rf_we", rf_we, 1'b0);
        chk1("mid_rst_empty", empty, 1'b1);
        chk1("mid_rst_hit", hit_a, 1'b0);
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        chk1("post_rst_empty", empty, 1'b1);
        chk1("post_rst_hit", hit_a, 1'b0);
        cyc();
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
